// File: rtl/pacman_mover.sv
// pacman_mover: steps Pac-Man one tile per STEP_DIV ticks and probes the four neighbour walls
module pacman_mover #(
  parameter int GRID_W   = 28,
  parameter int GRID_H   = 31,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int STEP_DIV = 4,
  parameter int START_X  = 13,
  parameter int START_Y  = 23
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           move_tick,
  input  logic [3:0]     curr_direction,
  output logic           wall_rd_en,
  output logic [X_W-1:0] wall_addr_x,
  output logic [Y_W-1:0] wall_addr_y,
  input  logic           wall_rd_data,
  output logic [3:0]     legal_moves,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           moved,
  output logic           busy
);
  localparam int TW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  typedef enum logic [2:0] {IDLE, STEP, REQ_L, REQ_R, REQ_U, REQ_D, CAP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic step_pending, wrap, top, bot, one_hot, go;
  logic [2:0] shadow;
  logic [X_W-1:0] xl, xr, addr_x_q;
  logic [Y_W-1:0] yu, yd, addr_y_q;
  assign wrap    = move_tick && tick_cnt == TW'(STEP_DIV - 1);
  assign xl      = pos_x == '0 ? X_W'(GRID_W - 1) : pos_x - X_W'(1);
  assign xr      = pos_x == X_W'(GRID_W - 1) ? '0 : pos_x + X_W'(1);
  assign top     = pos_y == '0;
  assign bot     = pos_y == Y_W'(GRID_H - 1);
  assign yu      = top ? pos_y : pos_y - Y_W'(1);
  assign yd      = bot ? pos_y : pos_y + Y_W'(1);
  assign one_hot = curr_direction != '0 && (curr_direction & (curr_direction - 4'd1)) == '0;
  assign go      = one_hot && |(curr_direction & legal_moves);
  assign busy        = state != IDLE && state != STEP;
  assign wall_rd_en  = busy && state != CAP;
  assign wall_addr_x = state == REQ_L ? xl : state == REQ_R ? xr
                     : (state == REQ_U || state == REQ_D) ? pos_x : addr_x_q;
  assign wall_addr_y = state == REQ_U ? yu : state == REQ_D ? yd
                     : (state == REQ_L || state == REQ_R) ? pos_y : addr_y_q;
  always_ff @(posedge clk)
    if (reset) state <= REQ_L;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = step_pending ? STEP : IDLE;
      STEP:    state_n = REQ_L;
      REQ_L:   state_n = REQ_R;
      REQ_R:   state_n = REQ_U;
      REQ_U:   state_n = REQ_D;
      REQ_D:   state_n = CAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x        <= X_W'(START_X);
      pos_y        <= Y_W'(START_Y);
      legal_moves  <= '0;
      moved        <= 1'b0;
      tick_cnt     <= '0;
      step_pending <= 1'b0;
      shadow       <= '0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
    end else begin
      addr_x_q     <= wall_addr_x;
      addr_y_q     <= wall_addr_y;
      moved        <= state == STEP && go;
      tick_cnt     <= wrap ? '0 : move_tick ? tick_cnt + TW'(1) : tick_cnt;
      step_pending <= wrap || (step_pending && state != IDLE);
      if (state == STEP && go) begin
        pos_x <= curr_direction[0] ? xl : curr_direction[1] ? xr : pos_x;
        pos_y <= curr_direction[2] ? yu : curr_direction[3] ? yd : pos_y;
      end
      // read data lags its request by one cycle, so each state captures the previous probe
      if (state == REQ_R) shadow[0] <= ~wall_rd_data;
      if (state == REQ_U) shadow[1] <= ~wall_rd_data;
      if (state == REQ_D) shadow[2] <= ~wall_rd_data & ~top;
      if (state == CAP)   legal_moves <= {~wall_rd_data & ~bot, shadow};
    end
  end
endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: table-driven moves plus wrap, edge, wall and mid-probe reset sequences
module tb_pacman_mover;
  logic clk = 0, reset = 1, move_tick = 0, wall_rd_en, wall_rd_data = 0, moved, busy;
  logic [3:0] curr_direction = 0, legal_moves;
  logic [4:0] wall_addr_x, wall_addr_y, pos_x, pos_y;
  bit wall [0:31][0:31];
  logic [9:0] reads [$];
  int checks = 0, failures = 0, moved_cnt = 0;

  typedef struct {
    logic [3:0] dir;
    logic [4:0] x, y;
    logic [3:0] legal;
    int mv;
  } vec_t;
  vec_t tv [6];

  pacman_mover dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .curr_direction(curr_direction),
    .wall_rd_en(wall_rd_en), .wall_addr_x(wall_addr_x), .wall_addr_y(wall_addr_y),
    .wall_rd_data(wall_rd_data), .legal_moves(legal_moves), .pos_x(pos_x), .pos_y(pos_y),
    .moved(moved), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) wall_rd_data <= wall_rd_en ? wall[wall_addr_x][wall_addr_y] : 1'b0;

  always @(negedge clk) begin
    if (!reset && wall_rd_en) reads.push_back({wall_addr_x, wall_addr_y});
    if (moved) moved_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] d);
    curr_direction = d;
    moved_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 move_tick = 1;
      @(posedge clk); #1 move_tick = 0;
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{4'b0010, 14, 23, 4'hF, 1};
    tv[1] = '{4'b0000, 14, 23, 4'hF, 0};
    tv[2] = '{4'b0011, 14, 23, 4'hF, 0};
    tv[3] = '{4'b0001, 13, 23, 4'hF, 1};
    tv[4] = '{4'b1000, 13, 24, 4'hF, 1};
    tv[5] = '{4'b0100, 13, 23, 4'hF, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_pos_x", pos_x, 13);
    check("rst_pos_y", pos_y, 23);
    check("rst_legal", legal_moves, 0);
    check("rst_moved", moved, 0);
    check("rst_busy", busy, 1);
    reset = 0;
    reads.delete();
    repeat (10) @(posedge clk);
    #1;
    check("init_nreads", reads.size(), 4);
    if (reads.size() == 4) begin
      check("init_rd_l", reads[0], {5'd12, 5'd23});
      check("init_rd_r", reads[1], {5'd14, 5'd23});
      check("init_rd_u", reads[2], {5'd13, 5'd22});
      check("init_rd_d", reads[3], {5'd13, 5'd24});
    end
    check("init_legal", legal_moves, 4'hF);
    check("init_busy", busy, 0);

    foreach (tv[i]) begin
      step(tv[i].dir);
      check($sformatf("v%0d_x", i), pos_x, tv[i].x);
      check($sformatf("v%0d_y", i), pos_y, tv[i].y);
      check($sformatf("v%0d_legal", i), legal_moves, tv[i].legal);
      check($sformatf("v%0d_moved", i), moved_cnt, tv[i].mv);
    end

    wall[13][22] = 1;
    step(4'b0000);
    check("wall_legal", legal_moves, 4'b1011);
    step(4'b0100);
    check("wall_y", pos_y, 23);
    check("wall_moved", moved_cnt, 0);
    check("wall_legal2", legal_moves, 4'b1011);
    wall[13][22] = 0;
    step(4'b0000);
    check("unwall_legal", legal_moves, 4'hF);

    for (int i = 0; i < 14; i++) step(4'b0010);
    check("pre_wrap_x", pos_x, 27);
    reads.delete();
    step(4'b0010);
    check("wrap_x", pos_x, 0);
    check("wrap_moved", moved_cnt, 1);
    check("wrap_rd_l", reads.size() > 0 ? reads[0] : 10'h3FF, {5'd27, 5'd23});

    for (int i = 0; i < 22; i++) step(4'b0100);
    check("pre_top_y", pos_y, 1);
    reads.delete();
    step(4'b0100);
    check("top_y", pos_y, 0);
    check("top_legal", legal_moves, 4'b1011);
    check("top_rd_u", reads.size() > 2 ? reads[2] : 10'h3FF, {5'd0, 5'd0});
    step(4'b0011);
    check("multi_x", pos_x, 0);
    check("multi_moved", moved_cnt, 0);
    step(4'b0100);
    check("top_up_y", pos_y, 0);
    check("top_up_moved", moved_cnt, 0);

    reads.delete();
    curr_direction = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 move_tick = 1;
      @(posedge clk); #1 move_tick = 0;
    end
    begin
      int n = 0;
      while (reads.size() < 3 && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (reads.size() < 3) check("req_u_timeout", 0, 1);
    end
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_x", pos_x, 13);
    check("mid_rst_y", pos_y, 23);
    check("mid_rst_legal", legal_moves, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_addr_x", wall_addr_x, 12);
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_legal", legal_moves, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
